// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Requester indices, request payload and slot finder.
package mem_arb_pkg;

  localparam int NrReqDef     = 3;
  localparam int TidWidthDef  = 2;
  localparam int AddrWidthDef = 64;
  localparam int DataWidthDef = 64;
  localparam int IdWidthDef   = $clog2(NrReqDef) + TidWidthDef;

  localparam int ReqIcache   = 0;
  localparam int ReqDcacheRd = 1;
  localparam int ReqStore    = 2;

  // Widest slot mask the finder handles (TidWidth up to MaxTid).
  localparam int MaxTid   = 4;
  localparam int MaxSlots = 1 << MaxTid;

  typedef struct packed {
    logic [AddrWidthDef-1:0]   addr;
    logic                      we;
    logic [DataWidthDef-1:0]   wdata;
    logic [DataWidthDef/8-1:0] be;
    logic [IdWidthDef-1:0]     id;
  } mem_req_t;

  // Returns {found, index} of the lowest clear bit in busy.
  function automatic logic [MaxTid:0] find_free(
    input logic [MaxSlots-1:0] busy
  );
    logic [MaxTid:0] res;
    res = '0;
    for (int i = MaxSlots - 1; i >= 0; i--) begin
      if (!busy[i]) res = {1'b1, MaxTid'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin picker with a registered priority pointer.
// The pointer moves past the winner only when a grant is made.
module rr_arbiter #(
  parameter  int N    = 3,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  logic [IdxW-1:0] ptr_q;

  // Pick the first requester at or after the pointer.
  always_comb begin
    int c;
    c     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_q) + k) % N;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IdxW'(c);
      end
    end
  end

  // Advance the pointer to winner + 1, wrapping at N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (valid) begin
      if (idx == IdxW'(N - 1)) ptr_q <= '0;
      else                     ptr_q <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer for icache, dcache read and store.
// Tags each request with {requester, slot} and tracks slots.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NrReq        = 3,
  parameter  int TidWidth     = 2,
  parameter  int MaxOutStores = 7,
  parameter  int AddrWidth    = 64,
  parameter  int DataWidth    = 64,
  localparam int IdWidth      = $clog2(NrReq) + TidWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrReq-1:0]                    req_valid_i,
  output logic [NrReq-1:0]                    req_ready_o,
  input  logic [NrReq-1:0][AddrWidth-1:0]     req_addr_i,
  input  logic [NrReq-1:0]                    req_we_i,
  input  logic [NrReq-1:0][DataWidth-1:0]     req_wdata_i,
  input  logic [NrReq-1:0][DataWidth/8-1:0]   req_be_i,
  output logic                                mem_req_valid_o,
  input  logic                                mem_req_ready_i,
  output logic [AddrWidth-1:0]                mem_req_addr_o,
  output logic                                mem_req_we_o,
  output logic [DataWidth-1:0]                mem_req_wdata_o,
  output logic [DataWidth/8-1:0]              mem_req_be_o,
  output logic [IdWidth-1:0]                  mem_req_id_o,
  input  logic                                mem_rsp_valid_i,
  input  logic [IdWidth-1:0]                  mem_rsp_id_i,
  output logic [NrReq-1:0]                    rsp_valid_o,
  input  logic                                flush_i,
  output logic                                idle_o,
  output logic                                bad_rsp_o
);

  localparam int Slots    = 2 ** TidWidth;
  localparam int ReqW     = $clog2(NrReq);
  localparam int StoreCap =
    (MaxOutStores < Slots) ? MaxOutStores : Slots;

  logic [NrReq-1:0][Slots-1:0]    busy_q;
  logic [NrReq-1:0][Slots-1:0]    busy_d;
  logic [NrReq-1:0][TidWidth-1:0] free_slot;
  logic [NrReq-1:0]               has_free;
  logic [NrReq-1:0]               eligible;
  logic [NrReq-1:0]               gnt;
  logic [NrReq-1:0]               rsp_hit;
  logic [ReqW-1:0]                gnt_idx;
  logic                           gnt_valid;
  logic [TidWidth:0]              store_cnt;
  logic                           load_ok;
  logic [ReqW-1:0]                rsp_r;
  logic [TidWidth-1:0]            rsp_s;
  logic                           out_valid_q;
  mem_req_t                       out_q;
  mem_req_t                       out_d;

  // Lowest free slot of every requester.
  always_comb begin
    logic [MaxSlots-1:0] ext;
    logic [MaxTid:0]     res;
    ext       = '1;
    res       = '0;
    has_free  = '0;
    free_slot = '0;
    for (int r = 0; r < NrReq; r++) begin
      ext             = '1;
      ext[Slots-1:0]  = busy_q[r];
      res             = find_free(ext);
      has_free[r]     = res[MaxTid];
      free_slot[r]    = res[TidWidth-1:0];
    end
  end

  assign store_cnt =
    (TidWidth + 1)'($countones(busy_q[ReqStore]));
  assign load_ok = !out_valid_q || mem_req_ready_i;

  // Who may compete for the port this cycle.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NrReq; r++) begin
      eligible[r] = rst_ni && req_valid_i[r] &&
                    !flush_i && has_free[r] && load_ok;
      if (r == ReqStore) begin
        eligible[r] = eligible[r] &&
                      (int'(store_cnt) < StoreCap);
      end
    end
  end

  rr_arbiter #(
    .N (NrReq)
  ) u_rr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   (eligible),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  assign req_ready_o = gnt;

  assign rsp_r = mem_rsp_id_i[IdWidth-1:TidWidth];
  assign rsp_s = mem_rsp_id_i[TidWidth-1:0];

  // Route a response to its owner if the slot is in flight.
  always_comb begin
    rsp_hit = '0;
    for (int r = 0; r < NrReq; r++) begin
      rsp_hit[r] = rst_ni && mem_rsp_valid_i &&
                   (rsp_r == ReqW'(r)) && busy_q[r][rsp_s];
    end
  end

  assign rsp_valid_o = rsp_hit;
  assign bad_rsp_o   = rst_ni && mem_rsp_valid_i && !(|rsp_hit);

  // Slot bookkeeping: free on response, claim on grant.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NrReq; r++) begin
      if (rsp_hit[r]) busy_d[r][rsp_s] = 1'b0;
    end
    if (gnt_valid) begin
      busy_d[gnt_idx][free_slot[gnt_idx]] = 1'b1;
    end
  end

  // Payload of the winning requester.
  always_comb begin
    out_d       = '0;
    out_d.addr  = req_addr_i[gnt_idx];
    out_d.we    = req_we_i[gnt_idx] &&
                  (gnt_idx == ReqW'(ReqStore));
    out_d.wdata = req_wdata_i[gnt_idx];
    out_d.be    = req_be_i[gnt_idx];
    out_d.id    = {gnt_idx, free_slot[gnt_idx]};
  end

  // Slot masks and the output request register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      busy_q <= busy_d;
      if (gnt_valid) begin
        out_valid_q <= 1'b1;
        out_q       <= out_d;
      end else if (mem_req_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign mem_req_valid_o = out_valid_q;
  assign mem_req_addr_o  = out_q.addr;
  assign mem_req_we_o    = out_q.we;
  assign mem_req_wdata_o = out_q.wdata;
  assign mem_req_be_o    = out_q.be;
  assign mem_req_id_o    = out_q.id;

  assign idle_o = !(|busy_q) && !out_valid_q;

endmodule
